coeff_sequencer: RTL and testbench

Parametrised coefficient load sequencer for the FIR filter datapath. On a new-coefficient-set request it issues one `load_coeff` strobe per enabled coefficient slot, in ascending index order, and waits for the datapath's `modwait` to drop between strobes. It generalises the fixed four-tap loader to `NUM_COEFFS` slots and adds a per-slot load mask, `busy` and `load_done` status outputs, and optional restart. It sits between the slave bus interface (`new_coefficient_set`, `coeff_mask`) and the MCU controller (`modwait` in; `load_coeff`/`coefficient_num` out).

---
 rtl/coeff_sequencer_if.sv | 35 +++
 rtl/coeff_sequencer.sv | 125 ++++++++++++
 tb/tb_coeff_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/coeff_sequencer_if.sv
// Handshake bundle between bus-side request logic, the coefficient sequencer
// and the MCU controller. The sequencer uses the slave modport.
interface coeff_sequencer_if #(
  parameter int unsigned NUM_COEFFS = 4
);
  localparam int unsigned IDX_W = $clog2(NUM_COEFFS);

  logic                  new_coefficient_set;
  logic [NUM_COEFFS-1:0] coeff_mask;
  logic                  modwait;
  logic                  load_coeff;
  logic [IDX_W-1:0]      coefficient_num;
  logic                  busy;
  logic                  load_done;

  modport master (
    output new_coefficient_set,
    output coeff_mask,
    output modwait,
    input  load_coeff,
    input  coefficient_num,
    input  busy,
    input  load_done
  );

  modport slave (
    input  new_coefficient_set,
    input  coeff_mask,
    input  modwait,
    output load_coeff,
    output coefficient_num,
    output busy,
    output load_done
  );
endinterface

// File: rtl/coeff_sequencer.sv
// Coefficient load sequencer: one load_coeff strobe per enabled mask slot, paced by modwait.
// Optional mid-sequence restart is enabled by defining COEFF_SEQ_RESTART_EN.
module coeff_sequencer #(
  parameter int unsigned NUM_COEFFS = 4
) (
  input  logic              clk,
  input  logic              reset,
  coeff_sequencer_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(NUM_COEFFS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [IDX_W-1:0]      idx, idx_next;
  logic [NUM_COEFFS-1:0] pend, pend_next;
  logic                  done_next;
  logic                  load_q, busy_q, done_q;

  logic                  start;
  logic                  restart;
  logic                  mask_any, pend_any;
  logic [IDX_W-1:0]      mask_lsb, pend_lsb;
  logic [NUM_COEFFS-1:0] mask_rest, pend_rest;

  // Index of the lowest set bit; zero for an empty vector.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_COEFFS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = int'(NUM_COEFFS) - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  assign start     = bus.new_coefficient_set && !bus.modwait;
  assign mask_any  = |bus.coeff_mask;
  assign pend_any  = |pend;
  assign mask_lsb  = lowest_set(bus.coeff_mask);
  assign pend_lsb  = lowest_set(pend);
  // v & (v-1) drops the lowest set bit, i.e. the slot about to be strobed.
  assign mask_rest = bus.coeff_mask & (bus.coeff_mask - NUM_COEFFS'(1));
  assign pend_rest = pend & (pend - NUM_COEFFS'(1));

`ifdef COEFF_SEQ_RESTART_EN
  assign restart = start;
`else
  assign restart = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      pend   <= '0;
      load_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      pend   <= pend_next;
      load_q <= (state_next == LOAD);
      busy_q <= (state_next != IDLE);
      done_q <= done_next;
    end
  end

  // Next-state: IDLE samples the mask, LOAD is always one cycle, WAIT paces on modwait.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    pend_next  = pend;
    done_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (mask_any) begin
            state_next = LOAD;
            idx_next   = mask_lsb;
            pend_next  = mask_rest;
          end else begin
            done_next  = 1'b1;
          end
        end
      end
      LOAD: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (restart) begin
          pend_next = mask_rest;
          if (mask_any) begin
            state_next = LOAD;
            idx_next   = mask_lsb;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else if (!bus.modwait) begin
          if (pend_any) begin
            state_next = LOAD;
            idx_next   = pend_lsb;
            pend_next  = pend_rest;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.load_coeff      = load_q;
  assign bus.busy            = busy_q;
  assign bus.load_done       = done_q;
  assign bus.coefficient_num = idx;
endmodule

// File: tb/tb_coeff_sequencer.sv
// Bench for coeff_sequencer: a 4-slot and an 8-slot instance driven from a vector
// table through an expected-value queue, plus a hand-written asynchronous reset sequence.
module tb_coeff_sequencer;
  logic clk;
  logic reset;

  coeff_sequencer_if #(.NUM_COEFFS(4)) b4 ();
  coeff_sequencer_if #(.NUM_COEFFS(8)) b8 ();

  coeff_sequencer #(.NUM_COEFFS(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
  coeff_sequencer #(.NUM_COEFFS(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef COEFF_SEQ_RESTART_EN
  localparam logic [7:0] R_IDX = 8'd7;
`else
  localparam logic [7:0] R_IDX = 8'd3;
`endif

  typedef struct {
    logic       big;
    logic       req;
    logic       mw;
    logic [7:0] mask;
    logic       e_load;
    logic [7:0] e_num;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  typedef struct {
    logic       big;
    logic       load;
    logic [7:0] num;
    logic       busy;
    logic       done;
    string      tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic big, input logic req, input logic mw,
                              input logic [7:0] mask, input logic ld,
                              input logic [7:0] num, input logic bsy, input logic dn);
    vec_t v;
    v.big = big; v.req = req; v.mw = mw; v.mask = mask;
    v.e_load = ld; v.e_num = num; v.e_busy = bsy; v.e_done = dn;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    if (e.big) begin
      check({e.tag, ".load"}, 8'(b8.load_coeff), 8'(e.load));
      check({e.tag, ".num"},  8'(b8.coefficient_num), e.num);
      check({e.tag, ".busy"}, 8'(b8.busy), 8'(e.busy));
      check({e.tag, ".done"}, 8'(b8.load_done), 8'(e.done));
    end else begin
      check({e.tag, ".load"}, 8'(b4.load_coeff), 8'(e.load));
      check({e.tag, ".num"},  8'(b4.coefficient_num), e.num);
      check({e.tag, ".busy"}, 8'(b4.busy), 8'(e.busy));
      check({e.tag, ".done"}, 8'(b4.load_done), 8'(e.done));
    end
  endtask

  // Drive one row before an edge, queue its expectation, compare just after the edge.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    if (v.big) begin
      b8.new_coefficient_set = v.req;
      b8.modwait             = v.mw;
      b8.coeff_mask          = v.mask;
    end else begin
      b4.new_coefficient_set = v.req;
      b4.modwait             = v.mw;
      b4.coeff_mask          = v.mask[3:0];
    end
    e.big = v.big; e.load = v.e_load; e.num = v.e_num;
    e.busy = v.e_busy; e.done = v.e_done; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_outputs(sb.pop_front());
  endtask

  initial begin
    exp_t z;
    reset = 1'b1;
    b4.new_coefficient_set = 1'b0; b4.modwait = 1'b0; b4.coeff_mask = '0;
    b8.new_coefficient_set = 1'b0; b8.modwait = 1'b0; b8.coeff_mask = '0;

    // Full 4-slot mask, modwait low: strobes every other cycle, done after final WAIT.
    vecs.push_back(mk(0, 1, 0, 8'h0F, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h0F, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h0F, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h0F, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h0F, 1, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h0F, 0, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h0F, 1, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h0F, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h0F, 0, 3, 0, 1));
    vecs.push_back(mk(0, 0, 0, 8'h0F, 0, 3, 0, 0));
    // Sparse mask 1010, modwait high three cycles after each strobe.
    vecs.push_back(mk(0, 1, 0, 8'h0A, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h0A, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h0A, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h0A, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h0A, 1, 3, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h0A, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h0A, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h0A, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h0A, 0, 3, 0, 1));
    vecs.push_back(mk(0, 0, 0, 8'h0A, 0, 3, 0, 0));
    // Empty mask: done pulse only, never busy.
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 3, 0, 1));
    vecs.push_back(mk(0, 0, 0, 8'h00, 0, 3, 0, 0));
    // Request while modwait high in IDLE waits for modwait to fall.
    vecs.push_back(mk(0, 1, 1, 8'h04, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h04, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h04, 1, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h04, 0, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h04, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 8'h04, 0, 2, 0, 0));
    // 8 slots: request with mask 0x80 during WAIT after index 2.
    vecs.push_back(mk(1, 1, 0, 8'h0F, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 8'h0F, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 8'h0F, 1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 8'h0F, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 8'h0F, 1, 2, 1, 0));
    vecs.push_back(mk(1, 0, 0, 8'h0F, 0, 2, 1, 0));
    vecs.push_back(mk(1, 1, 0, 8'h80, 1, R_IDX, 1, 0));
    vecs.push_back(mk(1, 0, 0, 8'h80, 0, R_IDX, 1, 0));
    vecs.push_back(mk(1, 0, 0, 8'h80, 0, R_IDX, 0, 1));
    vecs.push_back(mk(1, 0, 0, 8'h80, 0, R_IDX, 0, 0));

    repeat (2) @(negedge clk);
    z.load = 1'b0; z.num = 8'd0; z.busy = 1'b0; z.done = 1'b0;
    z.big = 1'b0; z.tag = "reset4"; check_outputs(z);
    z.big = 1'b1; z.tag = "reset8"; check_outputs(z);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("row%0d", i));
    end

    // Asynchronous reset while in WAIT after index 1 of a full mask.
    step(mk(0, 1, 0, 8'h0F, 1, 0, 1, 0), "rst_a");
    step(mk(0, 0, 0, 8'h0F, 0, 0, 1, 0), "rst_b");
    step(mk(0, 0, 0, 8'h0F, 1, 1, 1, 0), "rst_c");
    step(mk(0, 0, 0, 8'h0F, 0, 1, 1, 0), "rst_d");
    #2 reset = 1'b1;
    #1;
    z.big = 1'b0; z.tag = "rst_async"; check_outputs(z);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(mk(0, 0, 0, 8'h0F, 0, 0, 0, 0), $sformatf("rst_after%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
